// File: rtl/psram_spi_ctrl_pkg.sv
// Shared definitions for the PSRAM SPI sequencer: device opcodes, frame lengths, controller
// state encoding and the byte-lane reordering helper.
package psram_spi_ctrl_pkg;

  localparam logic [7:0] PSRAM_OP_READ  = 8'h03;
  localparam logic [7:0] PSRAM_OP_WRITE = 8'h02;
  localparam logic [7:0] PSRAM_OP_RSTEN = 8'h66;
  localparam logic [7:0] PSRAM_OP_RST   = 8'h99;

  localparam logic [6:0] NBITS_CMD  = 7'd8;
  localparam logic [6:0] NBITS_XFER = 7'd64;

  typedef enum logic [2:0] {
    StPor,
    StRstEn,
    StGapEn,
    StRst,
    StGapRst,
    StIdle,
    StXfer,
    StGap
  } ctrl_state_e;

  // Lowest byte travels first on the wire, so the serial data field is the word byte-reversed.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/psram_spi_shifter.sv
// Generic SPI mode-0 shift engine for frames of 1..64 bits, MSB of tx first.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : load tx/nbits and begin a frame (first low phase in the next cycle)
//   nbits       : frame length in bits (1..64)
//   tx          : bits to send, left-aligned (tx[63] goes first)
//   done        : high in the final cycle of the last bit's high phase
//   rx          : received bits, right-aligned (last bit received in rx[0])
//   sclk, mosi  : SPI clock and serial output; miso: serial input
module psram_spi_shifter #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  nbits,
  input  logic [63:0] tx,
  output logic        done,
  output logic [63:0] rx,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [15:0] HalfLast = 16'(CLK_DIV - 1);
  localparam logic [15:0] SlotLast = 16'(2 * CLK_DIV - 1);

  logic        active_q;
  logic [15:0] cnt_q;
  logic [5:0]  bit_q;
  logic [6:0]  last_bit_q;
  logic [63:0] sh_q;
  logic [63:0] rx_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        slot_end;

  assign slot_end = active_q && (cnt_q == SlotLast);
  // Combinational so the owner can close the frame on the same edge that ends the last slot.
  assign done     = slot_end && ({1'b0, bit_q} == last_bit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q   <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      last_bit_q <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else if (start) begin
      active_q   <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      last_bit_q <= nbits - 7'd1;
      mosi_q     <= tx[63];
      sh_q       <= {tx[62:0], 1'b0};
      rx_q       <= '0;
      sclk_q     <= 1'b0;
    end else if (active_q) begin
      // Rising SCLK edge: sample MISO on the same clk edge that raises SCLK.
      if (cnt_q == HalfLast) begin
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[62:0], miso};
      end
      if (slot_end) begin
        sclk_q <= 1'b0;
        cnt_q  <= '0;
        if (done) begin
          active_q <= 1'b0;
          mosi_q   <= 1'b0;
        end else begin
          bit_q  <= bit_q + 6'd1;
          mosi_q <= sh_q[63];
          sh_q   <= {sh_q[62:0], 1'b0};
        end
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign rx   = rx_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/psram_spi_ctrl.sv
// SPI-mode sequencer for the serial PSRAM: power-up wait, reset-enable/reset commands, then
// single 32-bit word reads (0x03) and writes (0x02) for one bus master.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req, we, addr, wdata: transaction strobe (taken only while busy=0), direction, word
//                         address (byte address [22:2]) and write data
//   rdata, ready        : read data (updated on ready of a read), one-cycle completion pulse
//   busy, init_done     : controller occupied / power-up sequence finished
//   psram_*             : device pins (CE active-low, SCLK mode 0, MOSI=SIO0, MISO=SIO1,
//                         SIO2/SIO3 held high)
module psram_spi_ctrl
  import psram_spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned POR_CYCLES = 15000,
  parameter int unsigned CE_GAP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [20:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        init_done,
  output logic        psram_ce,
  output logic        psram_sclk,
  output logic        psram_mosi,
  input  logic        psram_miso,
  output logic        psram_sio2,
  output logic        psram_sio3
);

  localparam logic [31:0] PorLast = 32'(POR_CYCLES - 1);
  localparam logic [15:0] GapLast = 16'(CE_GAP - 1);

  ctrl_state_e state_q;
  logic [31:0] por_cnt_q;
  logic [15:0] gap_cnt_q;
  logic        ce_q;
  logic        busy_q;
  logic        ready_q;
  logic        init_done_q;
  logic        we_q;
  logic [31:0] rdata_q;

  logic        sh_start;
  logic        sh_done;
  logic [6:0]  sh_nbits;
  logic [63:0] sh_tx;
  logic [63:0] sh_rx;
  logic [31:0] rx_word;
  logic        por_last;
  logic        gap_last;
  logic        accept;

  assign por_last = (por_cnt_q == PorLast);
  assign gap_last = (gap_cnt_q == GapLast);
  assign accept   = (state_q == StIdle) && req && !busy_q;
  // The data field is the last 32 bits of the frame.
  assign rx_word  = 32'(sh_rx);

  // Frame launch: issued on the same edge that drops CE so the first low phase follows it.
  always_comb begin
    sh_start = 1'b0;
    sh_nbits = NBITS_CMD;
    sh_tx    = '0;
    case (state_q)
      StPor: begin
        if (por_last) begin
          sh_start = 1'b1;
          sh_tx    = {PSRAM_OP_RSTEN, 56'h0};
        end
      end
      StGapEn: begin
        if (gap_last) begin
          sh_start = 1'b1;
          sh_tx    = {PSRAM_OP_RST, 56'h0};
        end
      end
      StIdle: begin
        if (accept) begin
          sh_start = 1'b1;
          sh_nbits = NBITS_XFER;
          sh_tx    = {(we ? PSRAM_OP_WRITE : PSRAM_OP_READ), 1'b0, addr, 2'b00,
                      (we ? byte_swap32(wdata) : 32'h0)};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPor;
      por_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ce_q        <= 1'b1;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        StPor: begin
          if (por_last) begin
            ce_q    <= 1'b0;
            state_q <= StRstEn;
          end else begin
            por_cnt_q <= por_cnt_q + 32'd1;
          end
        end
        StRstEn: begin
          if (sh_done) begin
            ce_q      <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= StGapEn;
          end
        end
        StGapEn: begin
          if (gap_last) begin
            ce_q    <= 1'b0;
            state_q <= StRst;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        StRst: begin
          if (sh_done) begin
            ce_q      <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= StGapRst;
          end
        end
        StGapRst: begin
          if (gap_last) begin
            init_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        StIdle: begin
          if (accept) begin
            ce_q    <= 1'b0;
            busy_q  <= 1'b1;
            we_q    <= we;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (sh_done) begin
            ce_q      <= 1'b1;
            ready_q   <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= StGap;
            if (!we_q) begin
              rdata_q <= byte_swap32(rx_word);
            end
          end
        end
        StGap: begin
          if (gap_last) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        default: state_q <= StPor;
      endcase
    end
  end

  psram_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (sh_start),
    .nbits (sh_nbits),
    .tx    (sh_tx),
    .done  (sh_done),
    .rx    (sh_rx),
    .sclk  (psram_sclk),
    .mosi  (psram_mosi),
    .miso  (psram_miso)
  );

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign init_done  = init_done_q;
  assign psram_ce   = ce_q;
  assign psram_sio2 = 1'b1;
  assign psram_sio3 = 1'b1;

endmodule

// File: tb/tb_psram_spi_ctrl.sv
// Bench for psram_spi_ctrl: byte-addressed PSRAM device model on the pins, word-level
// reference memory predicting read data, and queue-based frame/response scoreboards.
module tb_psram_spi_ctrl;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned POR_CYCLES = 100;
  localparam int unsigned CE_GAP     = 4;
  localparam int unsigned XFER_LAT   = 1 + 64 * 2 * CLK_DIV;

  typedef struct {
    int          nbits;
    logic [63:0] bits;
  } frame_t;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          acc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [20:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, busy, init_done;
  logic        ce, sclk, mosi, sio2, sio3;
  logic        miso = 1'b0;

  // Second instance exercising the fastest SCLK setting.
  logic        rst1 = 1'b0;
  logic        req1 = 1'b0;
  logic        we1 = 1'b0;
  logic [20:0] addr1 = '0;
  logic [31:0] wdata1 = '0;
  logic [31:0] rdata1;
  logic        ready1, busy1, init_done1, ce1, sclk1, mosi1, sio2_1, sio3_1;
  logic        miso1 = 1'b1;

  psram_spi_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .POR_CYCLES (POR_CYCLES),
    .CE_GAP     (CE_GAP)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .busy       (busy),
    .init_done  (init_done),
    .psram_ce   (ce),
    .psram_sclk (sclk),
    .psram_mosi (mosi),
    .psram_miso (miso),
    .psram_sio2 (sio2),
    .psram_sio3 (sio3)
  );

  psram_spi_ctrl #(
    .CLK_DIV    (1),
    .POR_CYCLES (20),
    .CE_GAP     (2)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst1),
    .req        (req1),
    .we         (we1),
    .addr       (addr1),
    .wdata      (wdata1),
    .rdata      (rdata1),
    .ready      (ready1),
    .busy       (busy1),
    .init_done  (init_done1),
    .psram_ce   (ce1),
    .psram_sclk (sclk1),
    .psram_mosi (mosi1),
    .psram_miso (miso1),
    .psram_sio2 (sio2_1),
    .psram_sio3 (sio3_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference contents ----------------
  function automatic logic [7:0] init_byte(input int a);
    return 8'(a ^ (a >> 9)) ^ 8'hA5;
  endfunction

  logic [7:0]  dev_mem [int];
  logic [31:0] ref_mem [int];

  function automatic logic [7:0] dev_byte(input int a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_byte(a);
  endfunction

  // Word at byte addresses 4a..4a+3, little-endian.
  function automatic logic [31:0] ref_read(input logic [20:0] a);
    logic [31:0] w;
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    for (int i = 0; i < 4; i++) w[8*i +: 8] = init_byte(int'({a, 2'b00}) + i);
    return w;
  endfunction

  frame_t exp_frames[$];
  resp_t  exp_resp[$];
  bit     in_abort = 1'b1;

  // ---------------- PSRAM device model ----------------
  int          bitn = 0;
  logic [63:0] obs = '0;
  logic [31:0] cmd = '0;
  logic [63:0] last_frame = '0;
  int          last_rise = 0;
  int          last_fall = 0;

  always @(negedge ce) begin
    bitn = 0;
    obs = '0;
    cmd = '0;
    last_fall = cyc;
    miso = 1'($urandom);
  end

  always @(posedge sclk) begin
    if (!ce) begin
      obs = {obs[62:0], mosi};
      bitn++;
      if (bitn == 32) cmd = obs[31:0];
    end
  end

  always @(negedge sclk) begin : dev_drive
    int k;
    logic [7:0] b;
    if (!ce) begin
      if (bitn >= 32 && bitn < 64 && cmd[31:24] == 8'h03) begin
        k = bitn - 32;
        b = dev_byte(int'(cmd[23:0]) + k / 8);
        miso = b[7 - (k % 8)];
      end else begin
        miso = 1'($urandom);
      end
    end
  end

  always @(posedge ce) begin : frame_mon
    frame_t f;
    last_rise = cyc;
    if (!in_abort) begin
      last_frame = obs;
      if (exp_frames.size() == 0) begin
        fail_now("frame_unexpected");
      end else begin
        f = exp_frames.pop_front();
        check("frame_len", 64'(bitn), 64'(f.nbits));
        check("frame_mosi", obs, f.bits);
      end
      if (bitn == 64 && cmd[31:24] == 8'h02) begin
        for (int i = 0; i < 4; i++) dev_mem[int'(cmd[23:0]) + i] = obs[31 - 8*i -: 8];
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin : resp_mon
    resp_t r;
    if (ready) begin
      if (exp_resp.size() == 0) begin
        fail_now("ready_unexpected");
      end else begin
        r = exp_resp.pop_front();
        check("ready_latency", 64'(cyc - r.acc), 64'(XFER_LAT));
        if (r.is_read) check("rdata", 64'(rdata), 64'(r.data));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] frame_bits(input logic w, input logic [20:0] a,
                                             input logic [31:0] d);
    logic [31:0] data_field;
    data_field = '0;
    if (w) for (int i = 0; i < 4; i++) data_field = {data_field[23:0], d[8*i +: 8]};
    return {(w ? 8'h02 : 8'h03), 1'b0, a, 2'b00, data_field};
  endfunction

  task automatic expect_txn(input logic w, input logic [20:0] a, input logic [31:0] d);
    frame_t f;
    resp_t  r;
    f.nbits = 64;
    f.bits = frame_bits(w, a, d);
    exp_frames.push_back(f);
    r.is_read = !w;
    r.data = w ? 32'h0 : ref_read(a);
    r.acc = cyc;
    exp_resp.push_back(r);
    if (w) ref_mem[int'(a)] = d;
  endtask

  task automatic issue(input logic w, input logic [20:0] a, input logic [31:0] d);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      fail_now("issue_timeout");
      return;
    end
    we = w;
    addr = a;
    wdata = d;
    req = 1'b1;
    expect_txn(w, a, d);
    @(negedge clk);
    req = 1'b0;
    we = 1'($urandom);
    addr = 21'($urandom);
    wdata = $urandom;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || exp_resp.size() != 0 || exp_frames.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) fail_now("idle_timeout");
  endtask

  task automatic init_seq();
    frame_t f;
    int rel;
    int guard;
    f.nbits = 8;
    f.bits = 64'h66;
    exp_frames.push_back(f);
    f.bits = 64'h99;
    exp_frames.push_back(f);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    in_abort = 1'b0;
    guard = 0;
    while (ce && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("por_wait", 64'(cyc - rel), 64'(POR_CYCLES));
    guard = 0;
    while (!init_done && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("init_done", 64'(init_done), 64'd1);
    check("busy_at_init_done", 64'(busy), 64'd0);
    check("init_frames_left", 64'(exp_frames.size()), 64'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int accepted;
    int guard;
    int rise1;
    int acc1;
    logic [63:0] obs1_keep;

    #1 rst = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ce", 64'(ce), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_sio", 64'({sio2, sio3}), 64'd3);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_init_done", 64'(init_done), 64'd0);
    rst1 = 1'b0;
    init_seq();

    // Directed write: frame must be 02 000040 EF BE AD DE.
    issue(1'b1, 21'h000010, 32'hDEADBEEF);
    wait_idle();
    check("write_frame_literal", last_frame, 64'h02000040_EFBEADDE);

    // Directed read: device bytes 78 56 34 12.
    dev_mem[32'h80] = 8'h78;
    dev_mem[32'h81] = 8'h56;
    dev_mem[32'h82] = 8'h34;
    dev_mem[32'h83] = 8'h12;
    ref_mem[32'h20] = 32'h12345678;
    issue(1'b0, 21'h000020, 32'h0);
    issue(1'b0, 21'h000010, 32'h0);
    wait_idle();
    check("read_frame_literal", last_frame, 64'h03000040_00000000);

    // Random mix over a small address pool so reads revisit written words.
    for (int n = 0; n < 24; n++) begin
      logic [20:0] a;
      a = ($urandom_range(0, 3) == 0) ? 21'($urandom) : 21'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1'($urandom), a, $urandom);
    end
    wait_idle();

    // Back-to-back with req held high.
    @(negedge clk);
    req = 1'b1;
    we = 1'b0;
    addr = 21'h5;
    accepted = 0;
    guard = 0;
    rise1 = 0;
    while (accepted < 2 && guard < 3000) begin
      if (!busy) begin
        expect_txn(1'b0, 21'h5, 32'h0);
        accepted++;
        if (accepted == 2) rise1 = last_rise;
      end
      @(negedge clk);
      guard++;
    end
    req = 1'b0;
    check("b2b_accepts", 64'(accepted), 64'd2);
    check("b2b_gap", 64'(last_fall - rise1), 64'(CE_GAP + 1));
    wait_idle();

    // Reset in the middle of a read frame.
    issue(1'b0, 21'h3, 32'h0);
    guard = 0;
    while (bitn < 20 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    in_abort = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("abort_ce", 64'(ce), 64'd1);
    check("abort_sclk", 64'(sclk), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_init_done", 64'(init_done), 64'd0);
    exp_frames.delete();
    exp_resp.delete();
    repeat (5) @(negedge clk);
    init_seq();
    issue(1'b1, 21'h6, 32'hCAFEF00D);
    issue(1'b0, 21'h6, 32'h0);
    wait_idle();

    // CLK_DIV=1 instance: top address, MISO held high.
    guard = 0;
    while (!init_done1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("div1_init_done", 64'(init_done1), 64'd1);
    @(negedge clk);
    req1 = 1'b1;
    addr1 = 21'h1FFFFF;
    acc1 = cyc;
    @(negedge clk);
    req1 = 1'b0;
    guard = 0;
    while (!ready1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    obs1_keep = obs1;
    check("div1_latency", 64'(cyc - acc1), 64'd129);
    check("div1_rdata", 64'(rdata1), 64'hFFFFFFFF);
    check("div1_frame", obs1_keep, 64'h037FFFFC_00000000);

    check("init_done_held", 64'(init_done), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  logic [63:0] obs1 = '0;
  always @(negedge ce1) obs1 = '0;
  always @(posedge sclk1) if (!ce1) obs1 = {obs1[62:0], mosi1};

endmodule
